riscv_register_file_mp: RTL and testbench

Parametrised multi-port integer register file for wider RV32I cores.
- Configurable read ports and write ports.
- Optional write-to-read bypass.
- Per-register busy scoreboard: set at issue, cleared at writeback.
- Hardware zero-initialisation sequence after reset; o_regfile_ready gates use.
- Sits between decode/issue (reads, busy check, issue) and writeback (writes).

---
 rtl/riscv_register_file_mp.sv | 148 ++++++++++++++
 tb/tb_riscv_register_file_mp.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_register_file_mp.sv
`default_nettype none
// ============================================================================
// Module      : riscv_register_file_mp
// Description : Multi-port RV32I integer register file. It has a per-register
//               busy scoreboard, an optional write-to-read bypass and a
//               hardware zero-initialisation sequence that runs after reset.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_register_file_mp #(
    parameter int XLEN   = 32,
    parameter int AW     = 5,
    parameter int NRP    = 2,
    parameter int NWP    = 1,
    parameter int BYPASS = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NRP*AW-1:0]    i_regfile_rs_addr,
    output logic [NRP*XLEN-1:0]  o_regfile_rs_data,
    output logic [NRP-1:0]       o_regfile_rs_busy,
    input  logic [NWP-1:0]       i_regfile_rd_wen,
    input  logic [NWP*AW-1:0]    i_regfile_rd_addr,
    input  logic [NWP*XLEN-1:0]  i_regfile_rd_data,
    input  logic                 i_regfile_issue_en,
    input  logic [AW-1:0]        i_regfile_issue_addr,
    output logic                 o_regfile_ready
);

    localparam int            c_num_regs = 2**AW;
    localparam logic [AW-1:0] c_last_idx = AW'(c_num_regs - 1);
    localparam logic [0:0]    c_st_init  = 1'b0;
    localparam logic [0:0]    c_st_run   = 1'b1;

    logic [0:0]          r_state;
    logic [0:0]          w_next_state;
    logic                w_ready;
    logic [AW-1:0]       r_cnt;
    logic [XLEN-1:0]     r_regs [c_num_regs];
    logic [c_num_regs-1:0] r_busy;
    logic [c_num_regs-1:0] w_busy_next;

    // State register: reset always restarts the zero-initialisation sweep
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= c_st_init;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: leave INIT once the last register has been cleared
    always_comb begin
        w_next_state = r_state;
        if (r_state == c_st_init && r_cnt == c_last_idx) begin
            w_next_state = c_st_run;
        end
    end

    // Output decode: the file is usable only in RUN
    always_comb begin
        w_ready = (r_state == c_st_run);
    end

    assign o_regfile_ready = w_ready;

    // Init sweep counter, one register per edge while in INIT
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (r_state == c_st_init) begin
            r_cnt <= r_cnt + AW'(1);
        end
    end

    // Storage: the reset edge leaves contents alone. INIT clears them one per
    // edge. In RUN the later write ports override earlier ones to the same
    // register, because the last non-blocking assignment wins.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            if (r_state == c_st_init) begin
                r_regs[r_cnt] <= '0;
            end else begin
                for (int w = 0; w < NWP; w++) begin
                    if (i_regfile_rd_wen[w] && i_regfile_rd_addr[w*AW +: AW] != '0) begin
                        r_regs[i_regfile_rd_addr[w*AW +: AW]] <= i_regfile_rd_data[w*XLEN +: XLEN];
                    end
                end
            end
        end
    end

    // Scoreboard update: writebacks clear first, then an issue sets the bit,
    // so a new producer wins over a same-cycle writeback
    always_comb begin
        w_busy_next = r_busy;
        for (int w = 0; w < NWP; w++) begin
            if (i_regfile_rd_wen[w] && i_regfile_rd_addr[w*AW +: AW] != '0) begin
                w_busy_next[i_regfile_rd_addr[w*AW +: AW]] = 1'b0;
            end
        end
        if (i_regfile_issue_en && i_regfile_issue_addr != '0) begin
            w_busy_next[i_regfile_issue_addr] = 1'b1;
        end
        w_busy_next[0] = 1'b0;
    end

    // Scoreboard register: cleared on reset, frozen during INIT
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_busy <= '0;
        end else if (r_state == c_st_run) begin
            r_busy <= w_busy_next;
        end
    end

    generate
        for (genvar p = 0; p < NRP; p++) begin : g_read_port
            logic [AW-1:0]   w_rs_addr;
            logic [XLEN-1:0] w_rs_data;
            logic            w_rs_busy;

            assign w_rs_addr = i_regfile_rs_addr[p*AW +: AW];

            // Combinational read with optional forwarding of in-flight writes
            always_comb begin
                w_rs_data = r_regs[w_rs_addr];
                w_rs_busy = r_busy[w_rs_addr];
                if (BYPASS != 0) begin
                    for (int w = 0; w < NWP; w++) begin
                        if (i_regfile_rd_wen[w] && i_regfile_rd_addr[w*AW +: AW] == w_rs_addr) begin
                            w_rs_data = i_regfile_rd_data[w*XLEN +: XLEN];
                            w_rs_busy = 1'b0;
                        end
                    end
                end
                if (!w_ready || w_rs_addr == '0) begin
                    w_rs_data = '0;
                    w_rs_busy = 1'b0;
                end
            end

            assign o_regfile_rs_data[p*XLEN +: XLEN] = w_rs_data;
            assign o_regfile_rs_busy[p]              = w_rs_busy;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_riscv_register_file_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_register_file_mp
// Description : Self-checking bench for riscv_register_file_mp. It drives a
//               bypassing and a non-bypassing instance with the same stimulus
//               and compares both against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_register_file_mp;

    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NRP  = 3;
    localparam int NWP  = 2;
    localparam int N    = 2**AW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic [NRP*AW-1:0]   rs_addr;
    logic [NWP-1:0]      wen;
    logic [NWP*AW-1:0]   wa;
    logic [NWP*XLEN-1:0] wd;
    logic                iss_en;
    logic [AW-1:0]       iss_a;

    logic [NRP*XLEN-1:0] d1_data, d0_data;
    logic [NRP-1:0]      d1_busy, d0_busy;
    logic                d1_ready, d0_ready;

    riscv_register_file_mp #(.XLEN(XLEN), .AW(AW), .NRP(NRP), .NWP(NWP), .BYPASS(1)) dut_byp (
        .i_clk(clk), .i_rst(rst),
        .i_regfile_rs_addr(rs_addr), .o_regfile_rs_data(d1_data), .o_regfile_rs_busy(d1_busy),
        .i_regfile_rd_wen(wen), .i_regfile_rd_addr(wa), .i_regfile_rd_data(wd),
        .i_regfile_issue_en(iss_en), .i_regfile_issue_addr(iss_a),
        .o_regfile_ready(d1_ready)
    );

    riscv_register_file_mp #(.XLEN(XLEN), .AW(AW), .NRP(NRP), .NWP(NWP), .BYPASS(0)) dut_nobyp (
        .i_clk(clk), .i_rst(rst),
        .i_regfile_rs_addr(rs_addr), .o_regfile_rs_data(d0_data), .o_regfile_rs_busy(d0_busy),
        .i_regfile_rd_wen(wen), .i_regfile_rd_addr(wa), .i_regfile_rd_data(wd),
        .i_regfile_issue_en(iss_en), .i_regfile_issue_addr(iss_a),
        .o_regfile_ready(d0_ready)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [XLEN-1:0] m_reg [N];
    bit              m_busy [N];
    int              init_left = 0;
    bit              m_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            init_left = N;
            for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            if (init_left > 0) begin
                m_reg[N - init_left] = '0;
                init_left--;
            end else begin
                for (int w = 0; w < NWP; w++) begin
                    if (wen[w] && wa[w*AW +: AW] != 0) begin
                        m_reg[wa[w*AW +: AW]]  = wd[w*XLEN +: XLEN];
                        m_busy[wa[w*AW +: AW]] = 1'b0;
                    end
                end
                if (iss_en && iss_a != 0) m_busy[iss_a] = 1'b1;
            end
        end
    end

    function automatic logic [XLEN-1:0] exp_data(input int p, input bit byp);
        logic [AW-1:0]   a;
        logic [XLEN-1:0] d;
        a = rs_addr[p*AW +: AW];
        if (init_left > 0 || a == 0) return '0;
        d = m_reg[a];
        if (byp)
            for (int w = 0; w < NWP; w++)
                if (wen[w] && wa[w*AW +: AW] == a) d = wd[w*XLEN +: XLEN];
        return d;
    endfunction

    function automatic logic exp_busy(input int p, input bit byp);
        logic [AW-1:0] a;
        logic          b;
        a = rs_addr[p*AW +: AW];
        if (init_left > 0 || a == 0) return 1'b0;
        b = m_busy[a];
        if (byp)
            for (int w = 0; w < NWP; w++)
                if (wen[w] && wa[w*AW +: AW] == a) b = 1'b0;
        return b;
    endfunction

    // Every-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (m_valid) begin
            chk("ready_byp", XLEN'(d1_ready), XLEN'(init_left == 0));
            chk("ready_nobyp", XLEN'(d0_ready), XLEN'(init_left == 0));
            for (int p = 0; p < NRP; p++) begin
                chk("data_byp", d1_data[p*XLEN +: XLEN], exp_data(p, 1'b1));
                chk("busy_byp", XLEN'(d1_busy[p]), XLEN'(exp_busy(p, 1'b1)));
                chk("data_nobyp", d0_data[p*XLEN +: XLEN], exp_data(p, 1'b0));
                chk("busy_nobyp", XLEN'(d0_busy[p]), XLEN'(exp_busy(p, 1'b0)));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wen    = '0;
        wa     = '0;
        wd     = '0;
        iss_en = 1'b0;
        iss_a  = '0;
    endtask

    task automatic set_rs(input int p, input int a);
        rs_addr[p*AW +: AW] = AW'(a);
    endtask

    task automatic set_wr(input int w, input int a, input logic [XLEN-1:0] d);
        wen[w]              = 1'b1;
        wa[w*AW +: AW]      = AW'(a);
        wd[w*XLEN +: XLEN]  = d;
    endtask

    // Reset pulse, then the ready flag must rise on exactly the N-th edge
    task automatic do_reset(input bit check_ready);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < N - 1; i++) begin
            tick();
            if (check_ready) chk("ready_low_in_init", XLEN'(d1_ready), 32'd0);
        end
        tick();
        if (check_ready) chk("ready_after_n_edges", XLEN'(d1_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        rs_addr = '0;
        idle();

        // Reset sequence and full zero readback
        do_reset(1'b1);
        for (int r = 0; r < N; r++) begin
            set_rs(0, r); set_rs(1, r); set_rs(2, r);
            #2;
            chk("init_zero", d1_data[0 +: XLEN], 32'h0);
            chk("init_zero_nb", d0_data[0 +: XLEN], 32'h0);
            tick();
        end

        // Basic write / read
        set_rs(0, 5);
        set_wr(0, 5, 32'hDEADBEEF);
        #2;
        chk("bypass_same_cycle", d1_data[0 +: XLEN], 32'hDEADBEEF);
        chk("nobypass_same_cycle", d0_data[0 +: XLEN], 32'h0);
        tick(); idle();
        #2;
        chk("write_next_cycle", d0_data[0 +: XLEN], 32'hDEADBEEF);

        // Write to x0 dropped
        set_rs(0, 0);
        set_wr(0, 0, 32'h1234);
        #2;
        chk("x0_same_cycle", d1_data[0 +: XLEN], 32'h0);
        tick(); idle();
        #2;
        chk("x0_after", d0_data[0 +: XLEN], 32'h0);

        // Two ports writing the same register: highest index wins
        set_rs(0, 7); set_rs(1, 8);
        set_wr(0, 7, 32'h11); set_wr(1, 7, 32'h22);
        #2;
        chk("conflict_bypass", d1_data[0 +: XLEN], 32'h22);
        chk("no_write_port", d1_data[XLEN +: XLEN], 32'h0);
        tick(); idle();
        #2;
        chk("conflict_stored", d0_data[0 +: XLEN], 32'h22);

        // Scoreboard
        set_rs(0, 3);
        iss_en = 1'b1; iss_a = 5'd3;
        tick(); idle();
        #2;
        chk("issue_sets_busy", XLEN'(d0_busy[0]), 32'd1);
        set_wr(0, 3, 32'h33);
        #2;
        chk("wb_bypass_busy", XLEN'(d1_busy[0]), 32'd0);
        chk("wb_nobypass_busy", XLEN'(d0_busy[0]), 32'd1);
        tick(); idle();
        #2;
        chk("wb_clears_busy", XLEN'(d0_busy[0]), 32'd0);
        set_wr(0, 3, 32'h44);
        iss_en = 1'b1; iss_a = 5'd3;
        tick(); idle();
        #2;
        chk("issue_wins_over_wb", XLEN'(d0_busy[0]), 32'd1);
        set_rs(0, 0);
        iss_en = 1'b1; iss_a = 5'd0;
        tick(); idle();
        #2;
        chk("issue_x0_ignored", XLEN'(d1_busy[0]), 32'd0);

        // Reset mid-run with live state
        set_rs(0, 9); set_rs(1, 4);
        set_wr(0, 9, 32'hCAFE);
        tick(); idle();
        iss_en = 1'b1; iss_a = 5'd9;
        tick(); idle();
        #2;
        chk("x9_busy_before_reset", XLEN'(d0_busy[0]), 32'd1);
        chk("x9_data_before_reset", d0_data[0 +: XLEN], 32'hCAFE);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #2;
        chk("midreset_ready", XLEN'(d1_ready), 32'd0);
        chk("midreset_data", d1_data[0 +: XLEN], 32'h0);
        // Writes and issues during INIT must be ignored
        for (int i = 0; i < N; i++) begin
            set_wr(0, 4, 32'hFF);
            iss_en = 1'b1; iss_a = 5'd4;
            tick();
        end
        idle();
        #2;
        chk("post_init_ready", XLEN'(d1_ready), 32'd1);
        chk("x9_cleared", d0_data[0 +: XLEN], 32'h0);
        chk("busy9_cleared", XLEN'(d0_busy[0]), 32'd0);
        chk("x4_not_written", d0_data[XLEN +: XLEN], 32'h0);
        chk("busy4_not_set", XLEN'(d0_busy[1]), 32'd0);

        // Randomized traffic; narrow address range forces collisions
        for (int c = 0; c < 3000; c++) begin
            idle();
            for (int p = 0; p < NRP; p++)
                set_rs(p, ($urandom_range(0, 3) == 0) ? $urandom_range(0, N - 1) : $urandom_range(0, 7));
            for (int w = 0; w < NWP; w++)
                if ($urandom_range(0, 1) == 1)
                    set_wr(w, ($urandom_range(0, 3) == 0) ? $urandom_range(0, N - 1) : $urandom_range(0, 7), $urandom);
            if ($urandom_range(0, 2) == 0) begin
                iss_en = 1'b1;
                iss_a  = AW'($urandom_range(0, 7));
            end
            rst = ($urandom_range(0, 399) == 0);
            tick();
        end
        rst = 1'b0;
        idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
